// File: rtl/leak_key_collector.sv
// leak_key_collector: rebuilds a KEY_W-bit secret from an LSB-first serial leak; LEAK_MAJORITY_EN enables 2-of-3 bit sampling
module leak_key_collector #(
  parameter int KEY_W = 128,
  parameter int BIT_PERIOD = 16,
  parameter int SAMPLE_OFFSET = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       leak_in,
  output logic [KEY_W-1:0]           key_out,
  output logic                       key_valid,
  output logic                       busy,
  output logic [$clog2(KEY_W+1)-1:0] bit_count
);
  localparam int CW = $clog2(KEY_W+1);
  localparam int PW = $clog2(BIT_PERIOD);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t r_state, w_next;
  logic [PW-1:0] r_cnt;
  logic [CW-1:0] r_bc;
  logic [KEY_W-1:0] r_sr, r_key;
  logic w_last, w_done, w_shift, w_bit;
  assign w_last = r_cnt == PW'(BIT_PERIOD-1);
  assign w_done = w_last && r_bc == CW'(KEY_W-1);
`ifdef LEAK_MAJORITY_EN
  logic r_s0, r_s1;
  assign w_shift = r_cnt == PW'(SAMPLE_OFFSET+1);
  assign w_bit = (r_s0 & r_s1) | (r_s0 & leak_in) | (r_s1 & leak_in);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0 <= 1'b0;
      r_s1 <= 1'b0;
    end else begin
      if (r_cnt == PW'(SAMPLE_OFFSET-1)) r_s0 <= leak_in;
      if (r_cnt == PW'(SAMPLE_OFFSET)) r_s1 <= leak_in;
    end
  end
`else
  assign w_shift = r_cnt == PW'(SAMPLE_OFFSET);
  assign w_bit = leak_in;
`endif
  // start wins in every state, so it restarts a frame even on the completing edge
  always_comb begin
    w_next = start ? SHIFT : (r_state == SHIFT) ? (w_done ? DONE : SHIFT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_bc <= '0;
      r_sr <= '0;
      r_key <= '0;
    end else begin
      r_state <= w_next;
      if (start) begin
        r_cnt <= '0;
        r_bc <= '0;
        r_sr <= '0;
      end else if (r_state == SHIFT) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        if (w_shift) r_sr <= {w_bit, r_sr[KEY_W-1:1]};
        if (w_last) r_bc <= r_bc + 1'b1;
        if (w_done) r_key <= r_sr;
      end
    end
  end
  assign key_out = r_key;
  assign key_valid = r_state == DONE;
  assign busy = r_state != IDLE;
  assign bit_count = r_bc;
endmodule

// File: tb/tb_leak_key_collector.sv
// tb_leak_key_collector: randomized frames on two collector instances checked against a bit-level leak model
module tb_leak_key_collector;
  localparam int KW = 128;
  localparam int B_SO = 3;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  logic a_start = 0, a_leak = 0, b_start = 0, b_leak = 0;
  logic [KW-1:0] a_key, b_key;
  logic a_valid, a_busy, b_valid, b_busy;
  logic [7:0] a_bc, b_bc;
  int checks = 0, failures = 0;
  int cyc = 0, a_e0 = 0, a_vcyc = -1, a_vcnt = 0, b_vcnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (a_valid) begin
      a_vcnt <= a_vcnt + 1;
      a_vcyc <= cyc;
    end
    if (b_valid) b_vcnt <= b_vcnt + 1;
  end
  leak_key_collector #(.KEY_W(KW), .BIT_PERIOD(4), .SAMPLE_OFFSET(2)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .leak_in(a_leak), .key_out(a_key),
    .key_valid(a_valid), .busy(a_busy), .bit_count(a_bc));
  leak_key_collector #(.KEY_W(KW), .BIT_PERIOD(8), .SAMPLE_OFFSET(B_SO)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .leak_in(b_leak), .key_out(b_key),
    .key_valid(b_valid), .busy(b_busy), .bit_count(b_bc));

  function automatic logic [KW-1:0] rnd_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic a_pulse();
    a_start = 1;
    @(posedge clk); #1;
    a_start = 0;
    a_e0 = cyc;
  endtask

  task automatic a_bits(input logic [KW-1:0] k, input int n);
    for (int i = 0; i < n; i++) begin
      a_leak = k[i];
      repeat (4) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
    checks++; if (a_bc !== 8'd0) begin failures++; $display("FAIL reset_bit_count got=%0d exp=0", a_bc); end
    checks++; if (a_key !== '0) begin failures++; $display("FAIL reset_key got=%h exp=0", a_key); end
    checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", a_valid); end
    checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL reset_b_busy got=%b exp=0", b_busy); end
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [KW-1:0] k = 128'h000102030405060708090A0B0C0D0E0F;
    int n0 = a_vcnt;
    a_pulse();
    a_bits(k, KW);
    checks++; if (a_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", a_valid); end
    checks++; if (a_key !== k) begin failures++; $display("FAIL basic_key got=%h exp=%h", a_key, k); end
    checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL basic_busy_done got=%b exp=1", a_busy); end
    @(posedge clk); #1;
    checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_after got=%b exp=0", a_valid); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b exp=0", a_busy); end
    checks++; if (a_vcnt !== n0 + 1) begin failures++; $display("FAIL basic_pulses got=%0d exp=%0d", a_vcnt - n0, 1); end
    checks++; if (a_vcyc !== a_e0 + 512) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", a_vcyc - a_e0, 512); end
  endtask

  task automatic test_mid_reset();
    int n0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    n0 = a_vcnt;
    a_pulse();
    for (int i = 0; i < 200; i++) begin
      a_leak = 1'($urandom);
      @(posedge clk); #1;
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", a_busy); end
    checks++; if (a_bc !== 8'd0) begin failures++; $display("FAIL midrst_bit_count got=%0d exp=0", a_bc); end
    checks++; if (a_key !== '0) begin failures++; $display("FAIL midrst_key got=%h exp=0", a_key); end
    repeat (600) @(posedge clk);
    #1;
    checks++; if (a_vcnt !== n0) begin failures++; $display("FAIL midrst_no_valid got=%0d exp=0", a_vcnt - n0); end
  endtask

  task automatic test_restart();
    logic [KW-1:0] k0 = rnd_key(), k1 = rnd_key(), k2 = rnd_key();
    int n0;
    a_pulse();
    a_bits(k0, KW);
    @(posedge clk); #1;
    n0 = a_vcnt;
    a_pulse();
    a_bits(k1, 64);
    checks++; if (a_bc !== 8'd64) begin failures++; $display("FAIL restart_mid_count got=%0d exp=64", a_bc); end
    a_pulse();
    checks++; if (a_bc !== 8'd0) begin failures++; $display("FAIL restart_count got=%0d exp=0", a_bc); end
    checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL restart_busy got=%b exp=1", a_busy); end
    checks++; if (a_key !== k0) begin failures++; $display("FAIL restart_key_held got=%h exp=%h", a_key, k0); end
    a_bits(k2, KW);
    checks++; if (a_valid !== 1'b1) begin failures++; $display("FAIL restart_valid got=%b exp=1", a_valid); end
    checks++; if (a_key !== k2) begin failures++; $display("FAIL restart_key got=%h exp=%h", a_key, k2); end
    @(posedge clk); #1;
    checks++; if (a_vcnt !== n0 + 1) begin failures++; $display("FAIL restart_pulses got=%0d exp=1", a_vcnt - n0); end
    checks++; if (a_vcyc !== a_e0 + 512) begin failures++; $display("FAIL restart_latency got=%0d exp=512", a_vcyc - a_e0); end
  endtask

  task automatic test_boundary();
    logic [KW-1:0] p;
    int n0;
    for (int j = 0; j < 2; j++) begin
      p = (j == 0) ? '1 : '0;
      n0 = a_vcnt;
      a_pulse();
      a_bits(p, KW);
      checks++; if (a_valid !== 1'b1) begin failures++; $display("FAIL boundary_valid%0d got=%b exp=1", j, a_valid); end
      checks++; if (a_key !== p) begin failures++; $display("FAIL boundary_key%0d got=%h exp=%h", j, a_key, p); end
      @(posedge clk); #1;
      checks++; if (a_vcnt !== n0 + 1) begin failures++; $display("FAIL boundary_pulses%0d got=%0d exp=1", j, a_vcnt - n0); end
    end
  endtask

  task automatic test_back_to_back();
    logic [KW-1:0] k1 = rnd_key(), k2 = rnd_key();
    int n0 = a_vcnt;
    a_pulse();
    a_bits(k1, KW);
    checks++; if (a_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid1 got=%b exp=1", a_valid); end
    checks++; if (a_key !== k1) begin failures++; $display("FAIL b2b_key1 got=%h exp=%h", a_key, k1); end
    a_pulse();
    checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%b exp=1", a_busy); end
    checks++; if (a_bc !== 8'd0) begin failures++; $display("FAIL b2b_count got=%0d exp=0", a_bc); end
    checks++; if (a_vcnt !== n0 + 1) begin failures++; $display("FAIL b2b_first_pulse got=%0d exp=1", a_vcnt - n0); end
    a_bits(k2, KW);
    checks++; if (a_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid2 got=%b exp=1", a_valid); end
    checks++; if (a_key !== k2) begin failures++; $display("FAIL b2b_key2 got=%h exp=%h", a_key, k2); end
    @(posedge clk); #1;
    checks++; if (a_vcnt !== n0 + 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", a_vcnt - n0); end
    checks++; if (a_vcyc !== a_e0 + 512) begin failures++; $display("FAIL b2b_latency got=%0d exp=512", a_vcyc - a_e0); end
  endtask

  task automatic b_frame(input logic [KW-1:0] k, input bit rnd, output logic [KW-1:0] exp);
    logic [7:0] w;
    int g;
    b_start = 1;
    @(posedge clk); #1;
    b_start = 0;
    for (int i = 0; i < KW; i++) begin
      g = rnd ? int'($urandom_range(0, 7)) : B_SO;
      for (int c = 0; c < 8; c++) begin
        w[c] = (c == g) ? ~k[i] : k[i];
        b_leak = w[c];
        @(posedge clk); #1;
      end
`ifdef LEAK_MAJORITY_EN
      exp[i] = (int'(w[B_SO-1]) + int'(w[B_SO]) + int'(w[B_SO+1])) >= 2;
`else
      exp[i] = w[B_SO];
`endif
    end
  endtask

  task automatic test_majority();
    logic [KW-1:0] k = {16{8'hA5}}, exp, want;
    int n0 = b_vcnt;
`ifdef LEAK_MAJORITY_EN
    want = k;
`else
    want = ~k;
`endif
    b_frame(k, 1'b0, exp);
    checks++; if (b_valid !== 1'b1) begin failures++; $display("FAIL maj_valid got=%b exp=1", b_valid); end
    checks++; if (b_key !== want) begin failures++; $display("FAIL maj_a5_key got=%h exp=%h", b_key, want); end
    checks++; if (b_key !== exp) begin failures++; $display("FAIL maj_model_key got=%h exp=%h", b_key, exp); end
    @(posedge clk); #1;
    k = rnd_key();
    b_frame(k, 1'b1, exp);
    checks++; if (b_key !== exp) begin failures++; $display("FAIL maj_rnd_key got=%h exp=%h", b_key, exp); end
    @(posedge clk); #1;
    checks++; if (b_vcnt !== n0 + 2) begin failures++; $display("FAIL maj_pulses got=%0d exp=2", b_vcnt - n0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mid_reset();
    test_restart();
    test_boundary();
    test_back_to_back();
    test_majority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
